song_reader: RTL

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_reader.sv | 87 ++++++++
 1 files changed

// File: rtl/song_reader.sv
// Song sequencer: walks up to 32 {note, duration} entries of the selected song
// in the song ROM and hands each one to the note player, one note at a time.
module song_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [1:0]  song,
  input  logic        note_done,
  output logic [6:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic [5:0]  note,
  output logic [5:0]  duration,
  output logic        new_note,
  output logic        song_done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, NOTE, WAIT, DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_note_idx;
  logic [1:0]  r_song_q;
  logic [5:0]  r_note;
  logic [5:0]  r_duration;
  logic        r_song_done;
  logic [5:0]  w_rom_dur;
  logic        w_song_same;

  assign w_rom_dur   = rom_data[5:0];
  assign w_song_same = (song == r_song_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_note_idx  <= '0;
      r_note      <= '0;
      r_duration  <= '0;
      r_song_done <= 1'b0;
      r_song_q    <= song;
    end else if (!w_song_same) begin
      r_state     <= IDLE;
      r_note_idx  <= '0;
      r_note      <= '0;
      r_duration  <= '0;
      r_song_done <= 1'b0;
      r_song_q    <= song;
    end else if (play) begin
      case (r_state)
        IDLE:  r_state <= FETCH;
        FETCH: r_state <= LOAD;
        LOAD: begin
          // A zero duration marks the end of the song; the last note stays on the outputs.
          if (w_rom_dur == '0) begin
            r_state     <= DONE;
            r_song_done <= 1'b1;
          end else begin
            r_note     <= rom_data[11:6];
            r_duration <= w_rom_dur;
            r_state    <= NOTE;
          end
        end
        NOTE:  r_state <= WAIT;
        WAIT: begin
          if (note_done) begin
            if (r_note_idx == 5'd31) begin
              r_state     <= DONE;
              r_song_done <= 1'b1;
            end else begin
              r_note_idx <= r_note_idx + 5'd1;
              r_state    <= FETCH;
            end
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE is only left on a play=1 edge, so this fires exactly once per note
  // even when the FSM is frozen inside NOTE.
  assign new_note  = (r_state == NOTE) && play && w_song_same;
  assign rom_addr  = {song, r_note_idx};
  assign note      = r_note;
  assign duration  = r_duration;
  assign song_done = r_song_done;

endmodule
